fp_operand_aligner: RTL

//  Pre-add alignment stage of the 32-bit IEEE-754 add/sub datapath; the inverse of post-add normalization.

---
 rtl/fp_operand_aligner.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fp_operand_aligner.sv
// Pre-add alignment for single-precision add/sub: picks the larger-exponent
// operand and right-shifts the other's significand STEP bits per cycle with GRS.
module fp_operand_aligner #(
    parameter int STEP      = 4,
    parameter int MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exponent_out,
    output logic [23:0] significand_big,
    output logic [26:0] significand_small,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swapped
);

    localparam int RW = $clog2(MAX_SHIFT + 1);
    localparam logic [RW-1:0] MAXR  = RW'(MAX_SHIFT);
    localparam logic [7:0]    MAX8  = 8'(MAX_SHIFT);
    localparam logic [RW-1:0] STEPR = RW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state_q, state_d;

    logic [26:0]   work_q, work_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [7:0]    p_exp_q, p_exp_d;
    logic [23:0]   p_sigb_q, p_sigb_d;
    logic          p_signb_q, p_signb_d;
    logic          p_signs_q, p_signs_d;
    logic          p_swap_q, p_swap_d;

    logic [7:0]    o_exp_q, o_exp_d;
    logic [23:0]   o_sigb_q, o_sigb_d;
    logic [26:0]   o_sigs_q, o_sigs_d;
    logic          o_signb_q, o_signb_d;
    logic          o_signs_q, o_signs_d;
    logic          o_swap_q, o_swap_d;

    logic [7:0]    eexp_a, eexp_b, eexp_big, eexp_small, diff;
    logic          swap_in;
    logic [31:0]   big_op, small_op;
    logic [23:0]   sigb_in;
    logic [26:0]   sigs_in;
    logic [RW-1:0] rem_in;

    always_comb begin
        eexp_a     = (operand_a[30:23] == 8'd0) ? 8'd1 : operand_a[30:23];
        eexp_b     = (operand_b[30:23] == 8'd0) ? 8'd1 : operand_b[30:23];
        swap_in    = (eexp_b > eexp_a);
        big_op     = swap_in ? operand_b : operand_a;
        small_op   = swap_in ? operand_a : operand_b;
        eexp_big   = swap_in ? eexp_b : eexp_a;
        eexp_small = swap_in ? eexp_a : eexp_b;
        diff       = eexp_big - eexp_small;
        rem_in     = (diff > MAX8) ? MAXR : diff[RW-1:0];
        sigb_in    = {|big_op[30:23], big_op[22:0]};
        sigs_in    = {|small_op[30:23], small_op[22:0], 3'b000};
    end

    logic [RW-1:0] k, rem_nx;
    logic [27:0]   mask;
    logic [26:0]   shifted, sig_nx;
    logic          lost;

    // Bits falling off the bottom fold into bit 0 so sticky never clears.
    always_comb begin
        k       = (rem_q > STEPR) ? STEPR : rem_q;
        mask    = (28'd1 << k) - 28'd1;
        lost    = |(work_q & mask[26:0]);
        shifted = work_q >> k;
        sig_nx  = {shifted[26:1], shifted[0] | lost};
        rem_nx  = rem_q - k;
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        rem_d     = rem_q;
        p_exp_d   = p_exp_q;
        p_sigb_d  = p_sigb_q;
        p_signb_d = p_signb_q;
        p_signs_d = p_signs_q;
        p_swap_d  = p_swap_q;
        o_exp_d   = o_exp_q;
        o_sigb_d  = o_sigb_q;
        o_sigs_d  = o_sigs_q;
        o_signb_d = o_signb_q;
        o_signs_d = o_signs_q;
        o_swap_d  = o_swap_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    p_exp_d   = eexp_big;
                    p_sigb_d  = sigb_in;
                    p_signb_d = big_op[31];
                    p_signs_d = small_op[31];
                    p_swap_d  = swap_in;
                    work_d    = sigs_in;
                    rem_d     = rem_in;
                    if (rem_in == '0) begin
                        o_exp_d   = eexp_big;
                        o_sigb_d  = sigb_in;
                        o_sigs_d  = sigs_in;
                        o_signb_d = big_op[31];
                        o_signs_d = small_op[31];
                        o_swap_d  = swap_in;
                        state_d   = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = sig_nx;
                rem_d  = rem_nx;
                if (rem_nx == '0) begin
                    o_exp_d   = p_exp_q;
                    o_sigb_d  = p_sigb_q;
                    o_sigs_d  = sig_nx;
                    o_signb_d = p_signb_q;
                    o_signs_d = p_signs_q;
                    o_swap_d  = p_swap_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            rem_q     <= '0;
            p_exp_q   <= '0;
            p_sigb_q  <= '0;
            p_signb_q <= 1'b0;
            p_signs_q <= 1'b0;
            p_swap_q  <= 1'b0;
            o_exp_q   <= '0;
            o_sigb_q  <= '0;
            o_sigs_q  <= '0;
            o_signb_q <= 1'b0;
            o_signs_q <= 1'b0;
            o_swap_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            p_exp_q   <= p_exp_d;
            p_sigb_q  <= p_sigb_d;
            p_signb_q <= p_signb_d;
            p_signs_q <= p_signs_d;
            p_swap_q  <= p_swap_d;
            o_exp_q   <= o_exp_d;
            o_sigb_q  <= o_sigb_d;
            o_sigs_q  <= o_sigs_d;
            o_signb_q <= o_signb_d;
            o_signs_q <= o_signs_d;
            o_swap_q  <= o_swap_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign exponent_out      = o_exp_q;
    assign significand_big   = o_sigb_q;
    assign significand_small = o_sigs_q;
    assign sign_big          = o_signb_q;
    assign sign_small        = o_signs_q;
    assign swapped           = o_swap_q;

endmodule
